// File: rtl/frame_sched_pkg.sv
// Shared types and default constants for the frame scheduler and its helpers.
package frame_sched_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_READY = 2'd1,
        ST_SWAP  = 2'd2
    } sched_state_e;

    typedef logic buf_idx_t;

    localparam int unsigned DEF_CE_DIV          = 2;
    localparam int unsigned DEF_FRAMES_PER_TICK = 2;

    function automatic buf_idx_t other_buf(input buf_idx_t b);
        return ~b;
    endfunction

endpackage

// File: rtl/btn_sync_latch.sv
// Synchronises the raw button, remembers any press during a frame and
// hands the frozen value to the renderer when a swap is accepted.
module btn_sync_latch (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic accept,
    output logic btn
);

    logic sync1_q, sync2_q, sticky_q, btn_q;
    logic sticky_d, btn_d;

    always_comb begin
        sticky_d = sticky_q | sync2_q;
        btn_d    = btn_q;
        if (accept) begin
            // A press seen in the accept cycle itself still belongs to this frame.
            btn_d    = sticky_q | sync2_q;
            sticky_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sticky_q <= 1'b0;
            btn_q    <= 1'b0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            sticky_q <= sticky_d;
            btn_q    <= btn_d;
        end
    end

    assign btn = btn_q;

endmodule

// File: rtl/frame_scheduler.sv
// Paces the renderer against display vblank: clock enable, swap handshake,
// front/back buffer flip, per-frame button freeze and dropped-frame counting.
module frame_scheduler
    import frame_sched_pkg::*;
#(
    parameter int unsigned CE_DIV          = DEF_CE_DIV,
    parameter int unsigned FRAMES_PER_TICK = DEF_FRAMES_PER_TICK,
    parameter int unsigned DROP_CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vsync_start,
    input  logic                      render_done,
    input  logic                      btn_raw,
    output logic                      render_ce,
    output logic                      swap,
    output logic                      btn,
    output logic                      front_sel,
    output logic                      back_sel,
    output logic                      frame_drop,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);

    localparam int unsigned CE_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam int unsigned VB_W = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
    localparam logic [CE_W-1:0] CE_LAST = CE_W'(CE_DIV - 1);
    localparam logic [VB_W-1:0] VB_LAST = VB_W'(FRAMES_PER_TICK - 1);

    sched_state_e              state_q, state_d;
    logic [CE_W-1:0]           ce_cnt_q, ce_cnt_d;
    logic                      render_ce_q, render_ce_d;
    logic [VB_W-1:0]           vb_cnt_q, vb_cnt_d;
    logic                      first_q, first_d;
    logic                      swap_q, swap_d;
    buf_idx_t                  front_q, front_d;
    logic                      drop_q, drop_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                      due;
    logic                      accept;

    // Free-running dividers, independent of the FSM.
    always_comb begin
        ce_cnt_d    = (ce_cnt_q == CE_LAST) ? '0 : ce_cnt_q + CE_W'(1);
        render_ce_d = (ce_cnt_q == CE_LAST);
        vb_cnt_d    = vb_cnt_q;
        if (vsync_start) begin
            vb_cnt_d = (vb_cnt_q == VB_LAST) ? '0 : vb_cnt_q + VB_W'(1);
        end
        due = vsync_start && (vb_cnt_q == VB_LAST);
    end

    always_comb begin
        state_d    = state_q;
        first_d    = 1'b0;
        swap_d     = swap_q;
        front_d    = front_q;
        drop_d     = 1'b0;
        drop_cnt_d = drop_cnt_q;
        accept     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (due) begin
                    drop_d = 1'b1;
                    if (drop_cnt_q != '1) begin
                        drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
                    end
                end
                // render_done may still reflect the previous frame right after a swap.
                if (!first_q && render_done) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (due) begin
                    state_d = ST_SWAP;
                    swap_d  = 1'b1;
                end
            end
            ST_SWAP: begin
                if (render_ce_q) begin
                    accept  = 1'b1;
                    swap_d  = 1'b0;
                    front_d = other_buf(front_q);
                    state_d = ST_RUN;
                    first_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            ce_cnt_q    <= '0;
            render_ce_q <= 1'b0;
            vb_cnt_q    <= '0;
            first_q     <= 1'b1;
            swap_q      <= 1'b0;
            front_q     <= 1'b0;
            drop_q      <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ce_cnt_q    <= ce_cnt_d;
            render_ce_q <= render_ce_d;
            vb_cnt_q    <= vb_cnt_d;
            first_q     <= first_d;
            swap_q      <= swap_d;
            front_q     <= front_d;
            drop_q      <= drop_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    btn_sync_latch u_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .accept  (accept),
        .btn     (btn)
    );

    assign render_ce  = render_ce_q;
    assign swap       = swap_q;
    assign front_sel  = front_q;
    assign back_sel   = other_buf(front_q);
    assign frame_drop = drop_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler with CE_DIV=2, FRAMES_PER_TICK=2 and a
// 2-bit drop counter so saturation is reachable.
module tb_frame_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vsync_start = 1'b0;
    logic       render_done = 1'b0;
    logic       btn_raw = 1'b0;
    logic       render_ce, swap, btn, front_sel, back_sel, frame_drop;
    logic [1:0] drop_count;

    int checks = 0;
    int errors = 0;

    frame_scheduler #(
        .CE_DIV          (2),
        .FRAMES_PER_TICK (2),
        .DROP_CNT_WIDTH  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vsync_start (vsync_start),
        .render_done (render_done),
        .btn_raw     (btn_raw),
        .render_ce   (render_ce),
        .swap        (swap),
        .btn         (btn),
        .front_sel   (front_sel),
        .back_sel    (back_sel),
        .frame_drop  (frame_drop),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_vsync();
        vsync_start = 1'b1;
        tick();
        vsync_start = 1'b0;
    endtask

    // Swap must stay high until the edge that follows a render_ce cycle;
    // at that edge buffers flip and btn takes its frozen value.
    task automatic run_swap_handshake(input logic exp_front, input logic exp_btn, input string name);
        bit   done;
        logic ce_before;
        done = 0;
        for (int i = 0; i < 4 && !done; i++) begin
            ce_before = render_ce;
            tick();
            checks++;
            if (ce_before) begin
                done = 1;
                if (swap !== 1'b0 || front_sel !== exp_front || back_sel !== ~exp_front || btn !== exp_btn) begin
                    errors++;
                    $display("FAIL %s accept: swap=%b front=%b back=%b btn=%b, want swap=0 front=%b back=%b btn=%b",
                             name, swap, front_sel, back_sel, btn, exp_front, ~exp_front, exp_btn);
                end
            end else if (swap !== 1'b1 || front_sel !== ~exp_front) begin
                errors++;
                $display("FAIL %s hold: swap=%b front=%b, want swap=1 front=%b", name, swap, front_sel, ~exp_front);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no render_ce cycle seen within 4 cycles", name);
        end
    endtask

    task automatic test_reset();
        logic exp_ce [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({render_ce, swap, btn, front_sel, back_sel, frame_drop, drop_count} !== 8'b0000_1000) begin
            errors++;
            $display("FAIL reset_values: ce=%b swap=%b btn=%b front=%b back=%b drop=%b cnt=%0d, want 0 0 0 0 1 0 0",
                     render_ce, swap, btn, front_sel, back_sel, frame_drop, drop_count);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (render_ce !== exp_ce[i] || swap !== 1'b0 || front_sel !== 1'b0 || frame_drop !== 1'b0) begin
                errors++;
                $display("FAIL reset_ce[%0d]: ce=%b swap=%b front=%b drop=%b, want ce=%b swap=0 front=0 drop=0",
                         i, render_ce, swap, front_sel, frame_drop, exp_ce[i]);
            end
        end
    endtask

    task automatic test_swap();
        render_done = 1'b1;
        tick();
        pulse_vsync();
        checks++;
        if (swap !== 1'b0) begin
            errors++;
            $display("FAIL swap_not_due: swap=%b, want 0", swap);
        end
        pulse_vsync();
        checks++;
        if (swap !== 1'b1 || frame_drop !== 1'b0) begin
            errors++;
            $display("FAIL swap_latency: swap=%b drop=%b, want swap=1 drop=0", swap, frame_drop);
        end
        run_swap_handshake(1'b1, 1'b0, "swap1");
        render_done = 1'b0;
    endtask

    task automatic test_drop();
        render_done = 1'b0;
        pulse_vsync();
        checks++;
        if (frame_drop !== 1'b0) begin
            errors++;
            $display("FAIL drop_not_due: drop=%b, want 0", frame_drop);
        end
        pulse_vsync();
        checks++;
        if (frame_drop !== 1'b1 || drop_count !== 2'd1 || swap !== 1'b0) begin
            errors++;
            $display("FAIL drop_pulse: drop=%b cnt=%0d swap=%b, want 1 1 0", frame_drop, drop_count, swap);
        end
        tick();
        checks++;
        if (frame_drop !== 1'b0 || drop_count !== 2'd1) begin
            errors++;
            $display("FAIL drop_one_cycle: drop=%b cnt=%0d, want 0 1", frame_drop, drop_count);
        end
        render_done = 1'b1;
        tick();
        pulse_vsync();
        pulse_vsync();
        checks++;
        if (swap !== 1'b1 || frame_drop !== 1'b0 || drop_count !== 2'd1) begin
            errors++;
            $display("FAIL drop_recover: swap=%b drop=%b cnt=%0d, want 1 0 1", swap, frame_drop, drop_count);
        end
        run_swap_handshake(1'b0, 1'b0, "swap_after_drop");
        render_done = 1'b0;
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        render_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pulse_vsync();
            pulse_vsync();
            checks++;
            if (drop_count !== exp_cnt[i] || frame_drop !== 1'b1) begin
                errors++;
                $display("FAIL saturate[%0d]: cnt=%0d drop=%b, want cnt=%0d drop=1",
                         i, drop_count, frame_drop, exp_cnt[i]);
            end
        end
    endtask

    task automatic test_button();
        btn_raw = 1'b1;
        tick();
        btn_raw = 1'b0;
        repeat (3) tick();
        checks++;
        if (btn !== 1'b0) begin
            errors++;
            $display("FAIL btn_frozen_before_swap: btn=%b, want 0", btn);
        end
        render_done = 1'b1;
        tick();
        pulse_vsync();
        pulse_vsync();
        run_swap_handshake(1'b1, 1'b1, "btn_swap1");
        render_done = 1'b0;
        repeat (2) tick();
        checks++;
        if (btn !== 1'b1) begin
            errors++;
            $display("FAIL btn_held_in_frame: btn=%b, want 1", btn);
        end
        render_done = 1'b1;
        tick();
        pulse_vsync();
        pulse_vsync();
        run_swap_handshake(1'b0, 1'b0, "btn_swap2");
        render_done = 1'b0;
    endtask

    task automatic test_reset_mid_swap();
        render_done = 1'b1;
        tick();
        pulse_vsync();
        pulse_vsync();
        checks++;
        if (swap !== 1'b1 || front_sel !== 1'b0 || drop_count !== 2'd3) begin
            errors++;
            $display("FAIL pre_reset_swap: swap=%b front=%b cnt=%0d, want 1 0 3", swap, front_sel, drop_count);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (swap !== 1'b0 || front_sel !== 1'b0 || back_sel !== 1'b1 || drop_count !== 2'd0 || frame_drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_swap: swap=%b front=%b back=%b cnt=%0d drop=%b, want 0 0 1 0 0",
                     swap, front_sel, back_sel, drop_count, frame_drop);
        end
        rst = 1'b0;
        render_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (swap !== 1'b0 || front_sel !== 1'b0) begin
                errors++;
                $display("FAIL post_reset[%0d]: swap=%b front=%b, want 0 0", i, swap, front_sel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_swap();
        test_drop();
        test_saturation();
        test_button();
        test_reset_mid_swap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
